// File: rtl/tile_load_sequencer_pkg.sv
// Shared types for the tile load sequencer: operand type, shape select,
// matrix id, load FSM states, AXI constants and the per-matrix beat table.
package params;

    typedef enum logic [1:0] {
        TYPE_FP32 = 2'd0,
        TYPE_FP16 = 2'd1,
        TYPE_INT8 = 2'd2,
        TYPE_INT4 = 2'd3
    } type_t;

    typedef enum logic [1:0] {
        RC_M32N8   = 2'd0,
        RC_M16N16  = 2'd1,
        RC_M8N32   = 2'd2,
        RC_ILLEGAL = 2'd3
    } rc_t;

    typedef enum logic [1:0] {
        MAT_A = 2'd0,
        MAT_B = 2'd1,
        MAT_C = 2'd2
    } mat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR_A,
        ST_R_A,
        ST_AR_B,
        ST_R_B,
        ST_AR_C,
        ST_R_C,
        ST_FIN
    } ld_state_t;

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of 32-byte beats that make up one matrix of the tile.
    function automatic logic [6:0] beats(input mat_t mat, input type_t dt, input rc_t rc);
        beats = 7'd32;
        case (mat)
            MAT_A: begin
                case (dt)
                    TYPE_FP32: beats = 7'd16;
                    TYPE_INT8: beats = (rc == RC_M32N8) ? 7'd64 : 7'd8;
                    default:   beats = 7'd8;
                endcase
            end
            MAT_B: begin
                case (dt)
                    TYPE_FP32, TYPE_FP16: beats = 7'd8;
                    default:              beats = 7'd16;
                endcase
            end
            default: beats = 7'd32;
        endcase
    endfunction

endpackage

// File: rtl/tile_load_sequencer_ar_gen.sv
// tls_ar_gen: AXI read-address register stage.
// A load pulse captures address/length and raises arvalid; both stay stable
// until arready. accepted flags the AR handshake cycle.
// Ports: clk, rst, load, load_addr, load_len, arready in;
//        arvalid, araddr, arlen, arsize, arburst, accepted out.
module tls_ar_gen
    import params::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_len,
    input  logic              arready,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              accepted
);

    assign arsize   = AXI_SIZE_32B;
    assign arburst  = AXI_BURST_INCR;
    assign accepted = arvalid & arready;

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
        end else if (load) begin
            arvalid <= 1'b1;
            araddr  <= load_addr;
            arlen   <= load_len;
        end else if (accepted) begin
            arvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tile_load_sequencer.sv
// tile_load_sequencer: loads one tile (A, then B, then C) over an AXI4 read
// port and feeds each beat to the operand transform stage.
// Ports: clk/rst; start + data_type/rc/base_a/b/c config; busy/done/err status;
//        AXI AR (araddr, arlen, arsize, arburst, arvalid, arready) and
//        R (rdata, rresp, rlast, rvalid, rready); transform outputs
//        t_data, t_burst_num, t_mat, t_rc, t_type, t_valid.
// Build option: define TLS_BEAT_CHECK_EN to check rlast against the beat table.
module tile_load_sequencer
    import params::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  type_t             data_type,
    input  rc_t               rc,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] t_data,
    output logic [5:0]        t_burst_num,
    output mat_t              t_mat,
    output rc_t               t_rc,
    output type_t             t_type,
    output logic              t_valid
);

    ld_state_t         state;
    logic [ADDR_W-1:0] base_b_q, base_c_q;
    logic [6:0]        count;
    logic              err_acc;
    logic              ar_load;
    logic [ADDR_W-1:0] ar_load_addr;
    logic [7:0]        ar_load_len;
    logic              ar_accepted;
    mat_t              cur_mat;
    logic              beat, bad;

    assign beat = rvalid & rready;
    assign bad  = (rresp != AXI_RESP_OKAY);

    always_comb begin
        cur_mat = MAT_A;
        case (state)
            ST_AR_B, ST_R_B: cur_mat = MAT_B;
            ST_AR_C, ST_R_C: cur_mat = MAT_C;
            default:         cur_mat = MAT_A;
        endcase
    end

`ifdef TLS_BEAT_CHECK_EN
    logic [6:0] cur_beats;
    assign cur_beats = beats(cur_mat, t_type, t_rc);
`endif

    tls_ar_gen #(.ADDR_W(ADDR_W)) u_ar_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ar_load),
        .load_addr (ar_load_addr),
        .load_len  (ar_load_len),
        .arready   (arready),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .accepted  (ar_accepted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_acc      <= 1'b0;
            count        <= '0;
            rready       <= 1'b0;
            t_data       <= '0;
            t_burst_num  <= '0;
            t_mat        <= MAT_A;
            t_rc         <= RC_M32N8;
            t_type       <= TYPE_FP32;
            t_valid      <= 1'b0;
            base_b_q     <= '0;
            base_c_q     <= '0;
            ar_load      <= 1'b0;
            ar_load_addr <= '0;
            ar_load_len  <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            t_valid <= 1'b0;
            ar_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        t_type   <= data_type;
                        t_rc     <= rc;
                        base_b_q <= base_b;
                        base_c_q <= base_c;
                        busy     <= 1'b1;
                        count    <= '0;
                        if (rc == RC_ILLEGAL) begin
                            err_acc <= 1'b1;
                            state   <= ST_FIN;
                        end else begin
                            err_acc      <= 1'b0;
                            ar_load      <= 1'b1;
                            ar_load_addr <= base_a;
                            ar_load_len  <= {1'b0, beats(MAT_A, data_type, rc) - 7'd1};
                            state        <= ST_AR_A;
                        end
                    end
                end
                ST_AR_A: if (ar_accepted) begin count <= '0; rready <= 1'b1; state <= ST_R_A; end
                ST_AR_B: if (ar_accepted) begin count <= '0; rready <= 1'b1; state <= ST_R_B; end
                ST_AR_C: if (ar_accepted) begin count <= '0; rready <= 1'b1; state <= ST_R_C; end
                ST_R_A, ST_R_B, ST_R_C: begin
                    if (beat) begin
                        t_data      <= rdata;
                        t_burst_num <= count[5:0];
                        t_mat       <= cur_mat;
                        if (bad)
                            err_acc <= 1'b1;
`ifdef TLS_BEAT_CHECK_EN
                        // Beats past the table length are drained but never forwarded.
                        t_valid <= !bad && (count < cur_beats);
                        if (rlast != (count == cur_beats - 7'd1))
                            err_acc <= 1'b1;
`else
                        t_valid <= !bad;
`endif
                        if (count != 7'h7F)
                            count <= count + 7'd1;
                        if (rlast) begin
                            rready <= 1'b0;
                            if (state == ST_R_A) begin
                                ar_load      <= 1'b1;
                                ar_load_addr <= base_b_q;
                                ar_load_len  <= {1'b0, beats(MAT_B, t_type, t_rc) - 7'd1};
                                state        <= ST_AR_B;
                            end else if (state == ST_R_B) begin
                                ar_load      <= 1'b1;
                                ar_load_addr <= base_c_q;
                                ar_load_len  <= {1'b0, beats(MAT_C, t_type, t_rc) - 7'd1};
                                state        <= ST_AR_C;
                            end else begin
                                state <= ST_FIN;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    err   <= err_acc;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
`timescale 1ns/1ps
module tb_tile_load_sequencer;
    import params::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 256;
`ifdef TLS_BEAT_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, start;
    type_t             data_type;
    rc_t               rc;
    logic [ADDR_W-1:0] base_a, base_b, base_c;
    logic              busy, done, err;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic [DATA_W-1:0] t_data;
    logic [5:0]        t_burst_num;
    mat_t              t_mat;
    rc_t               t_rc;
    type_t             t_type;
    logic              t_valid;

    tile_load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .data_type(data_type), .rc(rc),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy), .done(done), .err(err),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .t_data(t_data), .t_burst_num(t_burst_num), .t_mat(t_mat), .t_rc(t_rc),
        .t_type(t_type), .t_valid(t_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave control and logs
    int  ar_delay = 0, bad_mat = -1, bad_beat = 0, early_mat = -1, early_beat = 0;
    bit  gaps = 1'b0, abort = 1'b0;
    int  ar_n = 0, timeouts = 0, stable_bad = 0, last_hs_cyc = -1;
    logic [ADDR_W-1:0] ar_addr_q[$];
    logic [7:0]        ar_len_q[$];
    int                sent_mat[$], sent_idx[$];
    logic [DATA_W-1:0] sent_data[$];
    logic [1:0]        sent_resp[$];

    // monitor logs
    int                got_mat[$], got_num[$];
    logic [DATA_W-1:0] got_data[$];
    int    done_n = 0, done_cyc = -1, arvalid_cycles = 0, cfg_bad = 0;
    logic  done_err;
    type_t cur_ty;
    rc_t   cur_rc;

    // Reference beat table, straight from the tile format rules.
    function automatic int model_beats(int m, int ty, int r);
        if (m == 0) begin
            case (ty)
                0: return 16;
                1: return 8;
                2: return (r == 0) ? 64 : 8;
                default: return 8;
            endcase
        end
        if (m == 1) return (ty <= 1) ? 8 : 16;
        return 32;
    endfunction

    always @(negedge clk) begin
        if (t_valid === 1'b1) begin
            got_mat.push_back(int'(t_mat));
            got_num.push_back(int'(t_burst_num));
            got_data.push_back(t_data);
            if (t_rc !== cur_rc || t_type !== cur_ty) cfg_bad++;
        end
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
            done_err = err;
        end
        if (arvalid === 1'b1) arvalid_cycles++;
    end

    // AXI read slave
    logic [ADDR_W-1:0] s_a0;
    logic [7:0]        s_l0;
    int                s_m, s_nb;
    bit                s_r, s_hs;
    logic [DATA_W-1:0] s_d;
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            if (!abort && rst === 1'b0 && arvalid === 1'b1) begin
                s_a0 = araddr; s_l0 = arlen; s_m = ar_n;
                for (int d = 0; d < ar_delay && !abort; d++) begin
                    @(negedge clk);
                    if (araddr !== s_a0 || arlen !== s_l0 || arvalid !== 1'b1) stable_bad++;
                end
                if (!abort) begin
                    arready = 1'b1;
                    @(posedge clk); #1;
                    if (!abort) begin
                        ar_addr_q.push_back(s_a0);
                        ar_len_q.push_back(s_l0);
                        ar_n++;
                    end
                    @(negedge clk);
                    arready = 1'b0;
                    s_nb = (early_mat == s_m) ? early_beat + 1 : int'(s_l0) + 1;
                    for (int b = 0; b < s_nb && !abort; b++) begin
                        if (gaps) begin
                            rvalid = 1'b0;
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                        end
                        for (int k = 0; k < DATA_W / 32; k++) s_d[k*32 +: 32] = $urandom();
                        rvalid = 1'b1;
                        rdata  = s_d;
                        rlast  = (b == s_nb - 1);
                        rresp  = (s_m == bad_mat && b == bad_beat) ? 2'b10 : 2'b00;
                        s_hs = 1'b0;
                        for (int w = 0; w < 1000 && !s_hs && !abort; w++) begin
                            s_r = (rready === 1'b1);
                            @(posedge clk); #1;
                            if (s_r && !abort) begin
                                s_hs = 1'b1;
                                sent_mat.push_back(s_m);
                                sent_idx.push_back(b);
                                sent_data.push_back(s_d);
                                sent_resp.push_back(rresp);
                                last_hs_cyc = cyc;
                            end
                            @(negedge clk);
                        end
                        if (!s_hs && !abort) timeouts++;
                    end
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
            if (abort) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
        end
    end

    task automatic clear_logs(input type_t ty, input rc_t r);
        ar_addr_q.delete(); ar_len_q.delete();
        sent_mat.delete(); sent_idx.delete(); sent_data.delete(); sent_resp.delete();
        got_mat.delete(); got_num.delete(); got_data.delete();
        ar_n = 0; done_n = 0; done_cyc = -1; arvalid_cycles = 0; cfg_bad = 0;
        stable_bad = 0; timeouts = 0; last_hs_cyc = -1;
        cur_ty = ty; cur_rc = r;
    endtask

    function automatic logic [ADDR_W-1:0] rand_base();
        return ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 5);
    endfunction

    // Drives one tile, then scores it against the reference model.
    task automatic run_tile(input string name, input type_t ty, input rc_t r, input int extra_starts);
        logic [ADDR_W-1:0] bases [3];
        int st_cyc, exp_n, cnt[3];
        bit exp_err, illegal;
        int e_mat[$], e_num[$];
        logic [DATA_W-1:0] e_data[$];
        illegal = (r == RC_ILLEGAL);
        clear_logs(ty, r);
        for (int m = 0; m < 3; m++) bases[m] = rand_base();
        @(negedge clk);
        start = 1'b1; data_type = ty; rc = r;
        base_a = bases[0]; base_b = bases[1]; base_c = bases[2];
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_after_start got %b expected 1", name, busy); end
        for (int i = 0; i < extra_starts; i++) begin
            repeat (3) @(negedge clk);
            start = 1'b1; data_type = type_t'($urandom_range(0, 3)); rc = rc_t'($urandom_range(0, 3));
            base_a = rand_base();
            @(negedge clk);
            start = 1'b0;
        end
        for (int w = 0; w < 5000 && done_n == 0; w++) @(negedge clk);
        repeat (4) @(negedge clk);

        // expected results from the slave's log and the beat table
        exp_err = illegal;
        cnt = '{0, 0, 0};
        for (int i = 0; i < sent_mat.size(); i++) begin
            if (sent_resp[i] != 2'b00) exp_err = 1'b1;
            cnt[sent_mat[i]]++;
            if (sent_resp[i] == 2'b00 && (!CHECK || sent_idx[i] < model_beats(sent_mat[i], ty, r))) begin
                e_mat.push_back(sent_mat[i]);
                e_num.push_back(sent_idx[i] % 64);
                e_data.push_back(sent_data[i]);
            end
        end
        if (CHECK && !illegal)
            for (int m = 0; m < 3; m++) if (cnt[m] != model_beats(m, ty, r)) exp_err = 1'b1;

        vectors++;
        if (done_n != 1) begin miscompares++; $display("FAIL %s done_count got %0d expected 1", name, done_n); end
        vectors++;
        if (done_err !== exp_err) begin miscompares++; $display("FAIL %s err got %b expected %b", name, done_err, exp_err); end
        vectors++;
        if (illegal) begin
            if (done_cyc != st_cyc + 2 || arvalid_cycles != 0) begin
                miscompares++;
                $display("FAIL %s illegal_timing done_cyc got %0d expected %0d arvalid_cycles got %0d expected 0",
                         name, done_cyc, st_cyc + 2, arvalid_cycles);
            end
        end else if (done_cyc != last_hs_cyc + 1) begin
            miscompares++; $display("FAIL %s done_timing got cycle %0d expected %0d", name, done_cyc, last_hs_cyc + 1);
        end
        vectors++;
        if (ar_addr_q.size() != (illegal ? 0 : 3)) begin
            miscompares++; $display("FAIL %s ar_count got %0d expected %0d", name, ar_addr_q.size(), illegal ? 0 : 3);
        end else begin
            for (int m = 0; m < ar_addr_q.size(); m++) begin
                exp_n = model_beats(m, ty, r);
                vectors++;
                if (ar_addr_q[m] !== bases[m] || ar_len_q[m] !== 8'(exp_n - 1)) begin
                    miscompares++;
                    $display("FAIL %s ar%0d got addr %h len %0d expected addr %h len %0d",
                             name, m, ar_addr_q[m], ar_len_q[m], bases[m], exp_n - 1);
                end
            end
        end
        vectors++;
        if (got_mat.size() != e_mat.size()) begin
            miscompares++; $display("FAIL %s t_valid_count got %0d expected %0d", name, got_mat.size(), e_mat.size());
        end else begin
            for (int i = 0; i < e_mat.size(); i++) begin
                vectors++;
                if (got_mat[i] != e_mat[i] || got_num[i] != e_num[i] || got_data[i] !== e_data[i]) begin
                    miscompares++;
                    $display("FAIL %s t_beat%0d got mat %0d num %0d data %h expected mat %0d num %0d data %h",
                             name, i, got_mat[i], got_num[i], got_data[i], e_mat[i], e_num[i], e_data[i]);
                end
            end
        end
        vectors++;
        if (stable_bad != 0 || timeouts != 0 || cfg_bad != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s protocol got ar_unstable %0d r_timeouts %0d cfg_bad %0d busy %b expected 0 0 0 0",
                     name, stable_bad, timeouts, cfg_bad, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_type = TYPE_FP32; rc = RC_M32N8;
        base_a = '0; base_b = '0; base_c = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, err, arvalid, rready, t_valid, araddr, arlen, t_burst_num, t_mat, t_rc, t_type} !== '0
            || t_data !== '0) begin
            miscompares++; $display("FAIL reset_outputs got nonzero outputs expected all 0");
        end
        vectors++;
        if (arsize !== 3'b101 || arburst !== 2'b01) begin
            miscompares++; $display("FAIL ar_constants got size %b burst %b expected 101 01", arsize, arburst);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fp32_zero_wait();
        gaps = 1'b0; ar_delay = 0; bad_mat = -1; early_mat = -1;
        run_tile("fp32_zero_wait", TYPE_FP32, RC_M32N8, 0);
    endtask

    task automatic test_int8_gaps();
        gaps = 1'b1; ar_delay = 5; bad_mat = -1; early_mat = -1;
        run_tile("int8_gaps", TYPE_INT8, RC_M32N8, 0);
    endtask

    task automatic test_slverr();
        gaps = 1'b1; ar_delay = $urandom_range(0, 3); bad_mat = 1; bad_beat = 3; early_mat = -1;
        run_tile("slverr_b3", TYPE_FP16, RC_M16N16, 0);
        bad_mat = -1;
    endtask

    task automatic test_illegal_rc();
        gaps = 1'b0; ar_delay = 0; bad_mat = -1; early_mat = -1;
        run_tile("illegal_rc", type_t'($urandom_range(0, 3)), RC_ILLEGAL, 0);
    endtask

    task automatic test_busy_ignore();
        gaps = 1'b1; ar_delay = 1; bad_mat = -1; early_mat = -1;
        run_tile("start_while_busy", TYPE_FP32, RC_M8N32, 3);
    endtask

    task automatic test_reset_mid_burst();
        gaps = 1'b0; ar_delay = 0; bad_mat = -1; early_mat = -1;
        clear_logs(TYPE_FP32, RC_M32N8);
        @(negedge clk);
        start = 1'b1; data_type = TYPE_FP32; rc = RC_M32N8;
        base_a = rand_base(); base_b = rand_base(); base_c = rand_base();
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 2000 && sent_mat.size() < 18; w++) @(negedge clk);
        vectors++;
        if (sent_mat.size() < 18) begin
            miscompares++; $display("FAIL reset_mid_b reach_r_b got %0d beats expected >= 18", sent_mat.size());
        end
        abort = 1'b1; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, err, arvalid, rready, t_valid, araddr, arlen, t_burst_num, t_mat, t_rc, t_type} !== '0
            || t_data !== '0) begin
            miscompares++; $display("FAIL reset_mid_b outputs got nonzero outputs expected all 0");
        end
        rst = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        run_tile("after_reset", TYPE_INT4, RC_M16N16, 0);
    endtask

    task automatic test_early_rlast();
        gaps = 1'b0; ar_delay = 0; bad_mat = -1; early_mat = 2; early_beat = 20;
        run_tile("early_rlast_c20", TYPE_FP32, RC_M32N8, 0);
        early_mat = -1;
    endtask

    task automatic test_random();
        type_t ty;
        rc_t   r;
        for (int i = 0; i < 4; i++) begin
            ty = type_t'($urandom_range(0, 3));
            r  = (ty == TYPE_INT8) ? RC_M32N8 : rc_t'($urandom_range(0, 2));
            gaps = 1'($urandom_range(0, 1));
            ar_delay = $urandom_range(0, 3);
            early_mat = -1;
            if ($urandom_range(0, 1) == 1) begin
                bad_mat = $urandom_range(0, 2); bad_beat = $urandom_range(0, 7);
            end else begin
                bad_mat = -1;
            end
            run_tile("random", ty, r, 0);
        end
        bad_mat = -1;
    endtask

    initial begin
        test_reset();
        test_fp32_zero_wait();
        test_int8_gaps();
        test_slverr();
        test_illegal_rc();
        test_busy_ignore();
        test_reset_mid_burst();
        test_early_rlast();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion expected finish within budget");
        $fatal(1, "watchdog expired");
    end

endmodule
